// File: rtl/rsp_s2_dma_ahbic_pkg.sv
// rsp_s2_dma_ahbic_pkg
//   Shared AHB encodings and helpers for the rsp_s2_dma AHB bus matrix.
//   - htrans_t / hburst_t : AHB HTRANS and HBURST encodings
//   - burst_beats()       : beats-1 of a fixed-length burst (0 for SINGLE/INCR)
//   - idx_width()         : width of a port index for a given port count
package rsp_s2_dma_ahbic_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'b000,
    HBURST_INCR   = 3'b001,
    HBURST_WRAP4  = 3'b010,
    HBURST_INCR4  = 3'b011,
    HBURST_WRAP8  = 3'b100,
    HBURST_INCR8  = 3'b101,
    HBURST_WRAP16 = 3'b110,
    HBURST_INCR16 = 3'b111
  } hburst_t;

  // Beats remaining after the first beat of a burst.
  function automatic logic [3:0] burst_beats(input logic [2:0] hburst);
    logic [3:0] beats;
    case (hburst)
      HBURST_WRAP4,  HBURST_INCR4:  beats = 4'd3;
      HBURST_WRAP8,  HBURST_INCR8:  beats = 4'd7;
      HBURST_WRAP16, HBURST_INCR16: beats = 4'd15;
      default:                      beats = 4'd0;
    endcase
    return beats;
  endfunction

  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rsp_s2_dma_ahbic_rr_pick.sv
// rsp_s2_dma_ahbic_rr_pick
//   Combinational round-robin picker. Searches pending[] starting at
//   (ptr+1) mod NUM_REQ and wrapping, so input ptr is considered last.
//   Ports:
//     pending   in  NUM_REQ  request vector
//     ptr       in  IDX_W    last-served index (must be < NUM_REQ)
//     win_idx   out IDX_W    index of the winner (ptr when none)
//     win_valid out 1        a winner exists
module rsp_s2_dma_ahbic_rr_pick
  import rsp_s2_dma_ahbic_pkg::*;
#(
  parameter int NUM_REQ = 3,
  localparam int IDX_W  = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] pending,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   win_idx,
  output logic               win_valid
);

  // One extra bit so ptr + offset cannot overflow before the modulo.
  localparam int SUM_W = IDX_W + 1;

  logic [IDX_W-1:0]   cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0] cand_hit;

  // Candidate gi is the input gi+1 positions after ptr.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      logic [SUM_W-1:0] sum;
      assign sum          = {1'b0, ptr} + SUM_W'(gi + 1);
      assign cand_idx[gi] = (sum >= SUM_W'(NUM_REQ)) ? IDX_W'(sum - SUM_W'(NUM_REQ))
                                                     : sum[IDX_W-1:0];
      assign cand_hit[gi] = pending[cand_idx[gi]];
    end
  endgenerate

  // Nearest candidate wins: walk from the farthest so the nearest overwrites.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (cand_hit[k]) begin
        win_valid = 1'b1;
        win_idx   = cand_idx[k];
      end
    end
  end

endmodule

// File: rtl/rsp_s2_dma_ahbic_arb_out.sv
// rsp_s2_dma_ahbic_arb_out
//   Output-stage arbiter of one MI port. Round-robin grant among NUM_REQ
//   input stages, held across fixed-length bursts, BUSY and locked sequences.
//   Ports:
//     HCLK, HRESETn      clock, synchronous active-low reset
//     HREADYM            MI HREADY; low freezes all address-phase state
//     sel_req[N]         per-input decoder select for this MI
//     trans_req[2N]      per-input HTRANS (input i at [2i+1:2i])
//     burst_req[3N]      per-input HBURST (input i at [3i+2:3i])
//     lock_req[N]        per-input HMASTLOCK
//     addr_in_port       input owning the address phase
//     no_port            no input granted (output stage drives IDLE)
//     sel_m              HSELM, = ~no_port
//     active_req[N]      one-hot grant returned to the input decoders
//     data_in_port       input owning the data phase
//     data_valid         current data phase belongs to data_in_port
module rsp_s2_dma_ahbic_arb_out
  import rsp_s2_dma_ahbic_pkg::*;
#(
  parameter int NUM_REQ = 3,
  localparam int IDX_W  = idx_width(NUM_REQ)
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 HREADYM,
  input  logic [NUM_REQ-1:0]   sel_req,
  input  logic [2*NUM_REQ-1:0] trans_req,
  input  logic [3*NUM_REQ-1:0] burst_req,
  input  logic [NUM_REQ-1:0]   lock_req,
  output logic [IDX_W-1:0]     addr_in_port,
  output logic                 no_port,
  output logic                 sel_m,
  output logic [NUM_REQ-1:0]   active_req,
  output logic [IDX_W-1:0]     data_in_port,
  output logic                 data_valid
);

  logic [IDX_W-1:0] addr_reg;
  logic             no_port_reg;
  logic             ptr_valid_reg;   // some input has been granted since reset
  logic [3:0]       beat_cnt_reg, beat_cnt_next;
  logic             lock_reg, lock_next;
  logic [IDX_W-1:0] data_port_reg;
  logic             data_valid_reg;

  logic [1:0]         trans_arr [NUM_REQ];
  logic [2:0]         burst_arr [NUM_REQ];
  logic [NUM_REQ-1:0] pending;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_port
      assign trans_arr[gi]  = trans_req[2*gi +: 2];
      assign burst_arr[gi]  = burst_req[3*gi +: 3];
      assign pending[gi]    = sel_req[gi] & (trans_req[2*gi +: 2] == HTRANS_NONSEQ);
      assign active_req[gi] = ~no_port_reg & (addr_reg == IDX_W'(gi));
    end
  endgenerate

  logic       active;
  logic [1:0] trans_g;
  logic [2:0] burst_g;
  logic       lock_g;
  logic       hold;

  assign active  = ~no_port_reg;
  assign trans_g = trans_arr[addr_reg];
  assign burst_g = burst_arr[addr_reg];
  assign lock_g  = lock_req[addr_reg];

  // Next burst/lock state assuming the current beat is accepted (HREADYM=1).
  always_comb begin
    beat_cnt_next = beat_cnt_reg;
    lock_next     = lock_reg;
    if (active) begin
      case (trans_g)
        HTRANS_NONSEQ: beat_cnt_next = burst_beats(burst_g);
        HTRANS_SEQ:    beat_cnt_next = (beat_cnt_reg != 4'd0) ? beat_cnt_reg - 4'd1 : 4'd0;
        HTRANS_IDLE:   beat_cnt_next = 4'd0;
        default:       beat_cnt_next = beat_cnt_reg;
      endcase
      if (trans_g[1]) begin
        lock_next = lock_g;
      end else if ((trans_g == HTRANS_IDLE) && !lock_g) begin
        lock_next = 1'b0;
      end
    end
  end

  assign hold = active & ((beat_cnt_next != 4'd0) | lock_next | (trans_g == HTRANS_BUSY));

  // Until the first grant after reset there is no previous owner, so the
  // search is aimed to start at input 0.
  logic [IDX_W-1:0] pick_ptr;
  logic [IDX_W-1:0] win_idx;
  logic             win_valid;

  assign pick_ptr = ptr_valid_reg ? addr_reg : IDX_W'(NUM_REQ - 1);

  rsp_s2_dma_ahbic_rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .pending   (pending),
    .ptr       (pick_ptr),
    .win_idx   (win_idx),
    .win_valid (win_valid)
  );

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      addr_reg       <= '0;
      no_port_reg    <= 1'b1;
      ptr_valid_reg  <= 1'b0;
      beat_cnt_reg   <= 4'd0;
      lock_reg       <= 1'b0;
      data_port_reg  <= '0;
      data_valid_reg <= 1'b0;
    end else if (HREADYM) begin
      beat_cnt_reg   <= beat_cnt_next;
      lock_reg       <= lock_next;
      data_port_reg  <= addr_reg;
      data_valid_reg <= active & trans_g[1];
      if (!hold) begin
        if (win_valid) begin
          addr_reg      <= win_idx;
          no_port_reg   <= 1'b0;
          ptr_valid_reg <= 1'b1;
        end else begin
          // addr_reg kept: it is the round-robin pointer.
          no_port_reg <= 1'b1;
        end
      end
    end
  end

  assign addr_in_port = addr_reg;
  assign no_port      = no_port_reg;
  assign sel_m        = ~no_port_reg;
  assign data_in_port = data_port_reg;
  assign data_valid   = data_valid_reg;

endmodule

// File: tb/tb_rsp_s2_dma_ahbic_arb_out.sv
module tb_rsp_s2_dma_ahbic_arb_out;
  localparam int N = 3;
  localparam logic [1:0] T_IDLE = 2'd0, T_BUSY = 2'd1, T_NSEQ = 2'd2, T_SEQ = 2'd3;

  logic HCLK = 1'b0;
  logic HRESETn, HREADYM;
  logic [N-1:0]   sel_req, lock_req, active_req;
  logic [2*N-1:0] trans_req;
  logic [3*N-1:0] burst_req;
  logic [1:0]     addr_in_port, data_in_port;
  logic           no_port, sel_m, data_valid;

  always #5 HCLK = ~HCLK;

  rsp_s2_dma_ahbic_arb_out #(.NUM_REQ(N)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HREADYM(HREADYM),
    .sel_req(sel_req), .trans_req(trans_req), .burst_req(burst_req), .lock_req(lock_req),
    .addr_in_port(addr_in_port), .no_port(no_port), .sel_m(sel_m), .active_req(active_req),
    .data_in_port(data_in_port), .data_valid(data_valid)
  );

  // Each input is a scripted master: it presents the head of its script and
  // advances only when it owns the address phase and HREADYM is high.
  typedef struct packed { logic [1:0] t; logic [2:0] b; logic l; } xfer_t;
  xfer_t scr [N][64];
  int    head [N];
  int    tail [N];
  bit    rstn_v = 1'b0;
  bit    hready_v = 1'b1;
  int    total = 0;
  int    bad = 0;

  // Reference model: owner, burst beats left, lock, data phase.
  int m_owner, m_left, m_dport;
  bit m_none, m_fresh, m_lock, m_dvalid;

  function automatic void push(int i, logic [1:0] t, logic [2:0] b, logic l);
    xfer_t x;
    x.t = t; x.b = b; x.l = l;
    if (tail[i] < 64) begin
      scr[i][tail[i]] = x;
      tail[i]++;
    end
  endfunction

  function automatic void clear_scripts();
    for (int i = 0; i < N; i++) begin head[i] = 0; tail[i] = 0; end
  endfunction

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) if (head[i] != tail[i]) return 1'b0;
    return 1'b1;
  endfunction

  // 4, 8 or 16 beats for the fixed bursts, one beat otherwise.
  function automatic int beats_of(logic [2:0] hb);
    if (int'(hb) < 2) return 0;
    return (4 << ((int'(hb) - 2) / 2)) - 1;
  endfunction

  function automatic void model_reset();
    m_owner = 0; m_none = 1; m_fresh = 1; m_lock = 0; m_left = 0; m_dport = 0; m_dvalid = 0;
  endfunction

  function automatic void model_update();
    bit holdv;
    bit found;
    int start;
    logic [1:0] t;
    if (!rstn_v) begin model_reset(); return; end
    if (!hready_v) return;
    holdv = 0;
    m_dport = m_owner;
    m_dvalid = 0;
    if (!m_none) begin
      t = trans_req[2*m_owner +: 2];
      if (t == T_NSEQ) m_left = beats_of(burst_req[3*m_owner +: 3]);
      else if (t == T_SEQ) m_left = (m_left > 0) ? m_left - 1 : 0;
      else if (t == T_IDLE) m_left = 0;
      if (t[1]) m_lock = lock_req[m_owner];
      else if (t == T_IDLE && !lock_req[m_owner]) m_lock = 0;
      m_dvalid = t[1];
      holdv = (m_left != 0) || m_lock || (t == T_BUSY);
    end
    if (!holdv) begin
      start = m_fresh ? 0 : m_owner + 1;
      found = 0;
      for (int d = 0; d < N; d++) begin
        int c;
        c = (start + d) % N;
        if (!found && sel_req[c] && trans_req[2*c +: 2] == T_NSEQ) begin
          m_owner = c; found = 1;
        end
      end
      m_none = !found;
      if (found) m_fresh = 0;
    end
  endfunction

  function automatic logic [9:0] exp_vec();
    logic [2:0] act;
    act = m_none ? 3'b000 : (3'b001 << m_owner);
    return {2'(m_owner), m_none, ~m_none, act, 2'(m_dport), m_dvalid};
  endfunction

  task automatic drive();
    HRESETn = rstn_v;
    HREADYM = hready_v;
    for (int i = 0; i < N; i++) begin
      if (head[i] < tail[i]) begin
        sel_req[i] = 1'b1;
        trans_req[2*i +: 2] = scr[i][head[i]].t;
        burst_req[3*i +: 3] = scr[i][head[i]].b;
        lock_req[i] = scr[i][head[i]].l;
      end else begin
        sel_req[i] = 1'b0;
        trans_req[2*i +: 2] = T_IDLE;
        burst_req[3*i +: 3] = 3'd0;
        lock_req[i] = 1'b0;
      end
    end
  endtask

  // Drive, clock once, advance model and masters; returns at the negedge.
  task automatic step();
    bit cons [N];
    drive();
    @(posedge HCLK);
    for (int i = 0; i < N; i++)
      cons[i] = rstn_v && hready_v && !m_none && (m_owner == i) && (head[i] < tail[i]);
    model_update();
    for (int i = 0; i < N; i++) if (cons[i]) head[i]++;
    @(negedge HCLK);
  endtask

  task automatic do_reset();
    clear_scripts();
    rstn_v = 0;
    hready_v = 1;
    for (int k = 0; k < 3; k++) step();
    rstn_v = 1;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    rstn_v = 1;
    hready_v = 1;
    while (!(all_empty() && m_none)) begin
      step();
      if ({addr_in_port, no_port, sel_m, active_req, data_in_port, data_valid} !== exp_vec()) begin
        bad++; $display("FAIL drain t=%0t got=%b exp=%b", $time,
          {addr_in_port, no_port, sel_m, active_req, data_in_port, data_valid}, exp_vec());
      end
      total++;
      guard++;
      if (guard > 100) begin
        bad++; total++;
        $display("FAIL drain_timeout got=busy exp=idle within 100 cycles");
        break;
      end
    end
    clear_scripts();
  endtask

  task automatic test_reset();
    clear_scripts();
    push(0, T_NSEQ, 3'd0, 1'b0);
    push(2, T_NSEQ, 3'd0, 1'b0);
    rstn_v = 0;
    for (int k = 0; k < 3; k++) step();
    if (no_port !== 1'b1) begin bad++; $display("FAIL reset_no_port got=%b exp=1", no_port); end
    total++;
    if (active_req !== 3'b000) begin bad++; $display("FAIL reset_active_req got=%b exp=000", active_req); end
    total++;
    if (data_valid !== 1'b0) begin bad++; $display("FAIL reset_data_valid got=%b exp=0", data_valid); end
    total++;
    if (sel_m !== 1'b0) begin bad++; $display("FAIL reset_sel_m got=%b exp=0", sel_m); end
    total++;
    if (addr_in_port !== 2'd0) begin bad++; $display("FAIL reset_addr got=%0d exp=0", addr_in_port); end
    total++;
    rstn_v = 1;
    step();
    if (active_req !== 3'b001) begin bad++; $display("FAIL reset_first_grant got=%b exp=001", active_req); end
    total++;
    drain();
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < N; i++) for (int k = 0; k < 4; k++) push(i, T_NSEQ, 3'd0, 1'b0);
    for (int k = 0; k < 9; k++) begin
      step();
      if (no_port !== 1'b0 || addr_in_port !== 2'(k % N)) begin
        bad++; $display("FAIL rr_order k=%0d got=%0d/%b exp=%0d/0", k, addr_in_port, no_port, k % N);
      end
      total++;
      if ({addr_in_port, no_port, sel_m, active_req, data_in_port, data_valid} !== exp_vec()) begin
        bad++; $display("FAIL rr_model k=%0d got=%b exp=%b", k,
          {addr_in_port, no_port, sel_m, active_req, data_in_port, data_valid}, exp_vec());
      end
      total++;
    end
    drain();
  endtask

  task automatic test_fixed_burst();
    int cnt;
    logic [1:0] seq [10];
    seq = '{T_NSEQ, T_SEQ, T_BUSY, T_SEQ, T_SEQ, T_BUSY, T_SEQ, T_SEQ, T_SEQ, T_SEQ};
    for (int k = 0; k < 10; k++) push(1, seq[k], 3'd5, 1'b0);
    step();
    push(0, T_NSEQ, 3'd0, 1'b0);
    push(2, T_NSEQ, 3'd0, 1'b0);
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (!no_port && addr_in_port == 2'd1) cnt++;
      else break;
      step();
      if ({addr_in_port, no_port, sel_m, active_req, data_in_port, data_valid} !== exp_vec()) begin
        bad++; $display("FAIL burst_model k=%0d got=%b exp=%b", k,
          {addr_in_port, no_port, sel_m, active_req, data_in_port, data_valid}, exp_vec());
      end
      total++;
    end
    if (cnt !== 10) begin bad++; $display("FAIL burst_hold_cycles got=%0d exp=10", cnt); end
    total++;
    if (addr_in_port !== 2'd2 || no_port !== 1'b0) begin
      bad++; $display("FAIL burst_handover got=%0d/%b exp=2/0", addr_in_port, no_port);
    end
    total++;
    drain();
  endtask

  task automatic test_wait_states();
    int stalls;
    push(0, T_NSEQ, 3'd2, 1'b0);
    for (int k = 0; k < 3; k++) push(0, T_SEQ, 3'd2, 1'b0);
    step();
    push(1, T_NSEQ, 3'd0, 1'b0);
    stalls = 0;
    for (int k = 0; k < 20 && head[0] < tail[0]; k++) begin
      hready_v = !(head[0] == 2 && stalls < 4);
      if (!hready_v) stalls++;
      step();
      if (!hready_v) begin
        if (addr_in_port !== 2'd0 || no_port !== 1'b0 || data_in_port !== 2'd0 || data_valid !== 1'b1) begin
          bad++; $display("FAIL wait_frozen got=%0d/%b/%0d/%b exp=0/0/0/1",
            addr_in_port, no_port, data_in_port, data_valid);
        end
        total++;
      end
      if ({addr_in_port, no_port, sel_m, active_req, data_in_port, data_valid} !== exp_vec()) begin
        bad++; $display("FAIL wait_model k=%0d got=%b exp=%b", k,
          {addr_in_port, no_port, sel_m, active_req, data_in_port, data_valid}, exp_vec());
      end
      total++;
    end
    hready_v = 1;
    if (addr_in_port !== 2'd1 || no_port !== 1'b0) begin
      bad++; $display("FAIL wait_handover got=%0d/%b exp=1/0", addr_in_port, no_port);
    end
    total++;
    drain();
  endtask

  task automatic test_lock();
    logic [1:0] exp_owner [3];
    exp_owner = '{2'd2, 2'd2, 2'd0};
    push(2, T_NSEQ, 3'd0, 1'b1);
    push(2, T_NSEQ, 3'd0, 1'b1);
    push(2, T_IDLE, 3'd0, 1'b0);
    step();
    push(0, T_NSEQ, 3'd0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      if (addr_in_port !== exp_owner[k] || no_port !== 1'b0) begin
        bad++; $display("FAIL lock_owner k=%0d got=%0d/%b exp=%0d/0", k, addr_in_port, no_port, exp_owner[k]);
      end
      total++;
      if ({addr_in_port, no_port, sel_m, active_req, data_in_port, data_valid} !== exp_vec()) begin
        bad++; $display("FAIL lock_model k=%0d got=%b exp=%b", k,
          {addr_in_port, no_port, sel_m, active_req, data_in_port, data_valid}, exp_vec());
      end
      total++;
    end
    drain();
  endtask

  task automatic test_early_term();
    logic [1:0] exp_owner [3];
    exp_owner = '{2'd0, 2'd0, 2'd1};
    push(0, T_NSEQ, 3'd7, 1'b0);
    push(0, T_SEQ, 3'd7, 1'b0);
    push(0, T_IDLE, 3'd7, 1'b0);
    step();
    push(1, T_NSEQ, 3'd0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      if (addr_in_port !== exp_owner[k] || no_port !== 1'b0) begin
        bad++; $display("FAIL early_owner k=%0d got=%0d/%b exp=%0d/0", k, addr_in_port, no_port, exp_owner[k]);
      end
      total++;
    end
    drain();
  endtask

  task automatic test_reset_mid_burst();
    push(2, T_NSEQ, 3'd5, 1'b0);
    for (int k = 0; k < 7; k++) push(2, T_SEQ, 3'd5, 1'b0);
    step();
    for (int k = 0; k < 4; k++) step();
    rstn_v = 0;
    step();
    clear_scripts();
    if ({addr_in_port, no_port, sel_m, active_req, data_in_port, data_valid} !== 10'b00_1_0_000_00_0) begin
      bad++; $display("FAIL midreset_outputs got=%b exp=0010000000",
        {addr_in_port, no_port, sel_m, active_req, data_in_port, data_valid});
    end
    total++;
    rstn_v = 1;
    push(0, T_NSEQ, 3'd0, 1'b0);
    push(1, T_NSEQ, 3'd0, 1'b0);
    step();
    if (active_req !== 3'b001) begin bad++; $display("FAIL midreset_regrant got=%b exp=001", active_req); end
    total++;
    drain();
  endtask

  task automatic gen_xfer(int i);
    logic [2:0] bsel [6];
    logic [2:0] b;
    logic       lk;
    bsel = '{3'd0, 3'd3, 3'd2, 3'd5, 3'd4, 3'd6};
    head[i] = 0; tail[i] = 0;
    b  = bsel[$urandom_range(0, 5)];
    lk = ($urandom_range(0, 3) == 0);
    push(i, T_NSEQ, b, lk);
    for (int k = 0; k < beats_of(b); k++) begin
      if ($urandom_range(0, 4) == 0) push(i, T_BUSY, b, lk);
      push(i, T_SEQ, b, lk);
    end
    if (lk) push(i, T_IDLE, 3'd0, 1'b0);
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++)
        if (head[i] == tail[i] && $urandom_range(0, 3) == 0) gen_xfer(i);
      hready_v = ($urandom_range(0, 3) != 0);
      step();
      if ({addr_in_port, no_port, sel_m, active_req, data_in_port, data_valid} !== exp_vec()) begin
        bad++; $display("FAIL random_model c=%0d got=%b exp=%b", c,
          {addr_in_port, no_port, sel_m, active_req, data_in_port, data_valid}, exp_vec());
      end
      total++;
    end
    hready_v = 1;
    drain();
  endtask

  initial begin
    model_reset();
    clear_scripts();
    drive();
    test_reset();
    test_round_robin();
    test_fixed_burst();
    test_wait_states();
    test_lock();
    test_early_term();
    test_reset_mid_burst();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
